pc_gen: RTL

//   Parametrised program-counter generator for the fetch stage. Holds the fetch address,

---
 rtl/pc_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// PcGen (module pc_gen)
// Program-counter generator for the fetch stage. Holds the fetch address,
// issues it to instruction memory over a valid/ready handshake, advances by
// STEP on every accepted request and redirects on trap or branch/jump with
// trap taking priority. A misaligned branch target raises a one-cycle
// exception pulse, latches the offending address and freezes fetch until the
// trap logic redirects the PC.
//
// Ports
//   i_clk           clock, all state updates on the rising edge
//   i_reset_n       synchronous reset, active low
//   i_stall         decode back-pressure: hold PC, drop fetch_valid
//   i_brTaken       branch/jump redirect request (1-cycle qualifier)
//   i_brTarget      redirect target, sampled with i_brTaken
//   i_trapTaken     trap/exception redirect request
//   i_trapVector    trap handler base address (low 2 bits ignored)
//   i_fetchReady    instruction memory accepts the request this cycle
//   o_fetchValid    o_pc is a valid fetch request
//   o_pc            current fetch address (registered)
//   o_pcPlus        o_pc + STEP, carry discarded (link value)
//   o_misalignExc   one-cycle pulse after a misaligned branch target
//   o_misalignAddr  offending target, held until the next misalignment
// ---------------------------------------------------------------------------
module pc_gen #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          IALIGN       = 32,
  parameter int          STEP         = 4
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_stall,
  input  logic            i_brTaken,
  input  logic [XLEN-1:0] i_brTarget,
  input  logic            i_trapTaken,
  input  logic [XLEN-1:0] i_trapVector,
  input  logic            i_fetchReady,
  output logic            o_fetchValid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pcPlus,
  output logic            o_misalignExc,
  output logic [XLEN-1:0] o_misalignAddr
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    WAIT_TRAP
  } stateT;

  localparam logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_VECTOR);
  localparam logic [XLEN-1:0] STEP_INC  = XLEN'(STEP);
  localparam logic [XLEN-1:0] TRAP_MASK = ~XLEN'(3);

  stateT           r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_misalignExc;
  logic [XLEN-1:0] r_misalignAddr;

  logic            w_misaligned;
  logic [XLEN-1:0] w_trapPc;
  logic [XLEN-1:0] w_pcStep;

  // Compressed-instruction builds only require halfword alignment.
  assign w_misaligned = (IALIGN == 16) ? i_brTarget[0] : (i_brTarget[1:0] != 2'b00);

  // Trap handler address is forced to a word boundary.
  assign w_trapPc = i_trapVector & TRAP_MASK;

  assign w_pcStep = r_pc + STEP_INC;

  // A request is only offered while running; stall withdraws it combinationally
  // so decode back-pressure takes effect in the same cycle.
  assign o_fetchValid   = (r_state == RUN) && !i_stall;
  assign o_pc           = r_pc;
  assign o_pcPlus       = w_pcStep;
  assign o_misalignExc  = r_misalignExc;
  assign o_misalignAddr = r_misalignAddr;

  // Next-PC selection and state sequencing. Trap beats everything and is
  // honoured in every state; branches only count while running. A misaligned
  // branch never touches the PC: it parks the FSM until the trap arrives.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state        <= BOOT;
      r_pc           <= RESET_PC;
      r_misalignExc  <= 1'b0;
      r_misalignAddr <= '0;
    end else begin
      r_misalignExc <= 1'b0;
      if (i_trapTaken) begin
        r_pc    <= w_trapPc;
        r_state <= RUN;
      end else begin
        case (r_state)
          BOOT: begin
            r_state <= RUN;
          end
          RUN: begin
            if (i_brTaken) begin
              if (w_misaligned) begin
                r_misalignExc  <= 1'b1;
                r_misalignAddr <= i_brTarget;
                r_state        <= WAIT_TRAP;
              end else begin
                r_pc <= i_brTarget;
              end
            end else if (o_fetchValid && i_fetchReady) begin
              r_pc <= w_pcStep;
            end
          end
          WAIT_TRAP: begin
            r_state <= WAIT_TRAP;
          end
          default: begin
            r_state <= BOOT;
          end
        endcase
      end
    end
  end

endmodule
